deglitcher: RTL and testbench

- Input qualifier that complements the edge stretcher. The stretcher passes an edge immediately and then enforces a minimum hold time. This block does the reverse: it withholds an edge until the input has been stable for a minimum number of enabled samples.
- Used on pushbuttons, external request lines and arbiter request inputs to reject glitches before they reach downstream logic.
- Produces a settled level, one-cycle edge strobes, and a strobe for each rejected glitch.

---
 rtl/deglitcher.sv | 178 +++++++++++++++++
 tb/tb_deglitcher.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/deglitcher.sv
// Input qualifier: a level change is committed only after a run of matching enabled samples.
// Optional DEGLITCHER_SYNC_EN puts a two-flop synchronizer in front of the qualifier.
module deglitcher #(
    parameter int count      = 4,
    parameter int high_count = count,
    parameter int low_count  = count
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic in,
    output logic out,
    output logic valid,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int max_count = (high_count > low_count) ? high_count : low_count;
    localparam int counter_width = $clog2(max_count + 1);

    localparam logic [counter_width-1:0] high_thr = counter_width'(high_count);
    localparam logic [counter_width-1:0] low_thr  = counter_width'(low_count);

    typedef enum logic [2:0] {
        INIT,
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND
    } state_t;

    state_t state, state_next;

    logic [counter_width-1:0] counter, counter_next;
    logic [counter_width-1:0] inc, start, cand, thr;
    logic target, target_next;
    logic out_next, valid_next, rise_next, fall_next, glitch_next;
    logic sample;

`ifdef DEGLITCHER_SYNC_EN
    logic sync_0, sync_1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= in;
            sync_1 <= sync_0;
        end
    end

    assign sample = sync_1;
`else
    assign sample = in;
`endif

    assign inc   = counter + 1'b1;
    assign start = {{(counter_width-1){1'b0}}, enable};

    always_comb begin
        state_next  = state;
        counter_next = counter;
        target_next = target;
        out_next    = out;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = 1'b0;
        cand        = '0;
        thr         = sample ? high_thr : low_thr;

        unique case (state)
            INIT: begin
                // A new target level restarts the run with this cycle's sample.
                cand = (sample != target) ? start : (enable ? inc : counter);
                target_next = sample;
                if (cand == thr) begin
                    state_next   = sample ? HIGH : LOW;
                    counter_next = '0;
                    out_next     = sample;
                    rise_next    = sample;
                end else begin
                    counter_next = cand;
                end
            end
            LOW: begin
                if (sample) begin
                    if (start == high_thr) begin
                        state_next   = HIGH;
                        counter_next = '0;
                        out_next     = 1'b1;
                        rise_next    = 1'b1;
                    end else begin
                        state_next   = RISE_PEND;
                        counter_next = start;
                    end
                end
            end
            RISE_PEND: begin
                if (!sample) begin
                    state_next   = LOW;
                    counter_next = '0;
                    glitch_next  = 1'b1;
                end else if (enable) begin
                    if (inc == high_thr) begin
                        state_next   = HIGH;
                        counter_next = '0;
                        out_next     = 1'b1;
                        rise_next    = 1'b1;
                    end else begin
                        counter_next = inc;
                    end
                end
            end
            HIGH: begin
                if (!sample) begin
                    if (start == low_thr) begin
                        state_next   = LOW;
                        counter_next = '0;
                        out_next     = 1'b0;
                        fall_next    = 1'b1;
                    end else begin
                        state_next   = FALL_PEND;
                        counter_next = start;
                    end
                end
            end
            FALL_PEND: begin
                if (sample) begin
                    state_next   = HIGH;
                    counter_next = '0;
                    glitch_next  = 1'b1;
                end else if (enable) begin
                    if (inc == low_thr) begin
                        state_next   = LOW;
                        counter_next = '0;
                        out_next     = 1'b0;
                        fall_next    = 1'b1;
                    end else begin
                        counter_next = inc;
                    end
                end
            end
            default: begin
                state_next   = INIT;
                counter_next = '0;
                target_next  = 1'b0;
                out_next     = 1'b0;
            end
        endcase

        valid_next = (state_next == LOW) || (state_next == HIGH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            counter <= '0;
            target  <= 1'b0;
            out     <= 1'b0;
            valid   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            glitch  <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            target  <= target_next;
            out     <= out_next;
            valid   <= valid_next;
            rise    <= rise_next;
            fall    <= fall_next;
            glitch  <= glitch_next;
        end
    end

endmodule

// File: tb/tb_deglitcher.sv
// Directed bench for deglitcher: symmetric 4/4 instance and asymmetric 1/3 instance.
// Expected output vectors {out,valid,rise,fall,glitch} go through a scoreboard queue.
module tb_deglitcher;

    logic clock = 1'b0;
    logic reset_a, enable_a, in_a;
    logic reset_b, enable_b, in_b;
    logic out_a, valid_a, rise_a, fall_a, glitch_a;
    logic out_b, valid_b, rise_b, fall_b, glitch_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [4:0] v;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    deglitcher #(.count(4)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .enable(enable_a),
        .in    (in_a),
        .out   (out_a),
        .valid (valid_a),
        .rise  (rise_a),
        .fall  (fall_a),
        .glitch(glitch_a)
    );

    deglitcher #(.count(4), .high_count(1), .low_count(3)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .enable(enable_b),
        .in    (in_b),
        .out   (out_b),
        .valid (valid_b),
        .rise  (rise_b),
        .fall  (fall_b),
        .glitch(glitch_b)
    );

    task automatic compare();
        exp_t       e;
        logic [4:0] obs;
        e = exp_q.pop_front();
        obs = e.sel ? {out_b, valid_b, rise_b, fall_b, glitch_b}
                    : {out_a, valid_a, rise_a, fall_a, glitch_a};
        checks++;
        assert (obs === e.v)
        else begin
            errors++;
            $error("FAIL %s observed={out,valid,rise,fall,glitch}=%b expected=%b",
                   e.tag, obs, e.v);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input string tag, input bit sel, input logic i,
                        input logic en, input logic [4:0] ev);
        if (sel) begin
            in_b = i;
            enable_b = en;
        end else begin
            in_a = i;
            enable_a = en;
        end
        exp_q.push_back('{tag, sel, ev});
        @(posedge clock);
        #1;
        compare();
    endtask

    // Compare without advancing a clock (used around asynchronous reset).
    task automatic check_now(input string tag, input bit sel, input logic [4:0] ev);
        exp_q.push_back('{tag, sel, ev});
        #1;
        compare();
    endtask

    initial begin
        reset_a = 1'b1; enable_a = 1'b1; in_a = 1'b0;
        reset_b = 1'b1; enable_b = 1'b1; in_b = 1'b0;
        @(posedge clock);
        #1;
        check_now("reset_a", 1'b0, 5'b00000);
        check_now("reset_b", 1'b1, 5'b00000);
        reset_a = 1'b0;

        // Initial qualification of low level.
        step("init1", 0, 1'b0, 1'b1, 5'b00000);
        step("init2", 0, 1'b0, 1'b1, 5'b00000);
        step("init3", 0, 1'b0, 1'b1, 5'b00000);
        step("init4", 0, 1'b0, 1'b1, 5'b01000);

        // Clean rise.
        step("rise1", 0, 1'b1, 1'b1, 5'b00000);
        step("rise2", 0, 1'b1, 1'b1, 5'b00000);
        step("rise3", 0, 1'b1, 1'b1, 5'b00000);
        step("rise4", 0, 1'b1, 1'b1, 5'b11100);
        step("rise5", 0, 1'b1, 1'b1, 5'b11000);

        // Clean fall.
        step("fall1", 0, 1'b0, 1'b1, 5'b10000);
        step("fall2", 0, 1'b0, 1'b1, 5'b10000);
        step("fall3", 0, 1'b0, 1'b1, 5'b10000);
        step("fall4", 0, 1'b0, 1'b1, 5'b01010);
        step("fall5", 0, 1'b0, 1'b1, 5'b01000);

        // Short high pulse is rejected.
        step("glt1", 0, 1'b1, 1'b1, 5'b00000);
        step("glt2", 0, 1'b1, 1'b1, 5'b00000);
        step("glt3", 0, 1'b0, 1'b1, 5'b01001);
        step("glt4", 0, 1'b0, 1'b1, 5'b01000);

        // Counter holds while enable is low.
        step("en1", 0, 1'b1, 1'b1, 5'b00000);
        step("en2", 0, 1'b1, 1'b0, 5'b00000);
        step("en3", 0, 1'b1, 1'b1, 5'b00000);
        step("en4", 0, 1'b1, 1'b0, 5'b00000);
        step("en5", 0, 1'b1, 1'b1, 5'b00000);
        step("en6", 0, 1'b1, 1'b0, 5'b00000);
        step("en7", 0, 1'b1, 1'b1, 5'b11100);
        step("en8", 0, 1'b1, 1'b0, 5'b11000);

        // Fall glitch in HIGH is rejected too, even with enable low.
        step("fglt1", 0, 1'b0, 1'b1, 5'b10000);
        step("fglt2", 0, 1'b1, 1'b0, 5'b11001);

        step("back1", 0, 1'b0, 1'b1, 5'b10000);
        step("back2", 0, 1'b0, 1'b1, 5'b10000);
        step("back3", 0, 1'b0, 1'b1, 5'b10000);
        step("back4", 0, 1'b0, 1'b1, 5'b01010);

        // Reset in the middle of a pending rise at count 3.
        step("rp1", 0, 1'b1, 1'b1, 5'b00000);
        step("rp2", 0, 1'b1, 1'b1, 5'b00000);
        step("rp3", 0, 1'b1, 1'b1, 5'b00000);
        reset_a = 1'b1;
        check_now("rst_async", 0, 5'b00000);
        step("rst_hold", 0, 1'b1, 1'b1, 5'b00000);
        reset_a = 1'b0;
        step("req1", 0, 1'b1, 1'b1, 5'b00000);
        step("req2", 0, 1'b1, 1'b1, 5'b00000);
        step("req3", 0, 1'b1, 1'b1, 5'b00000);
        step("req4", 0, 1'b1, 1'b1, 5'b11100);
        step("req5", 0, 1'b1, 1'b1, 5'b11000);

        // Asymmetric thresholds: high_count=1, low_count=3.
        reset_b = 1'b0;
        step("b_init1", 1, 1'b0, 1'b1, 5'b00000);
        step("b_init2", 1, 1'b0, 1'b1, 5'b00000);
        step("b_init3", 1, 1'b0, 1'b1, 5'b01000);
        step("b_rise", 1, 1'b1, 1'b1, 5'b11100);
        step("b_hold", 1, 1'b1, 1'b1, 5'b11000);
        step("b_fall1", 1, 1'b0, 1'b1, 5'b10000);
        step("b_fall2", 1, 1'b0, 1'b1, 5'b10000);
        step("b_fall3", 1, 1'b0, 1'b1, 5'b01010);
        step("b_idle", 1, 1'b0, 1'b1, 5'b01000);
        step("b_noen", 1, 1'b1, 1'b0, 5'b00000);
        step("b_en", 1, 1'b1, 1'b1, 5'b11100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
